// File: rtl/shift_arb_ctrl_pkg.sv
// Shared definitions for the two-requester shift-register arbiter.
// Holds the data-width default, opcode encoding and controller state encoding.
package shift_arb_ctrl_pkg;

    localparam int DW_DEF = 4;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHR  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/shift_arb_ctrl_core.sv
// Shared DW-bit register: load, or logical shift right/left by 0..3 with zero fill.
// One operation per cycle; ld has priority over sr, sr over sl.
module shift_core
    import shift_arb_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          sr,
    input  logic          sl,
    input  logic [1:0]    s_cnt,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d_in;
        end else if (sr) begin
            q_d = q_q >> s_cnt;
        end else if (sl) begin
            q_d = q_q << s_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter in front of a shared shift register; one command in flight.
// Latency accept->rsp_valid = step count; response holds until rsp_ready, no accept meanwhile.
module shift_arb_ctrl
    import shift_arb_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic [2:0]    req0_cnt,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic [2:0]    req1_cnt,
    input  logic [DW-1:0] req1_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data
);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [2:0]    rem_q, rem_d;
    op_e           op_q, op_d;
    logic [DW-1:0] data_q, data_d;
    logic          id_q, id_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;

    logic          gnt_id;
    logic          accept;
    logic          is_shift;
    logic          last_step;
    logic [1:0]    step_amt;
    logic          in_exec;

    // A lone requester wins outright; rr only breaks ties.
    assign gnt_id     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && !gnt_id;
    assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid && gnt_id;
    assign accept     = req0_ready || req1_ready;

    assign in_exec   = (state_q == ST_EXEC);
    assign is_shift  = (op_q == OP_SHR) || (op_q == OP_SHL);
    assign step_amt  = (rem_q > 3'd3) ? 2'd3 : rem_q[1:0];
    assign last_step = !is_shift || (rem_q <= 3'd3);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        rem_d       = rem_q;
        op_d        = op_q;
        data_d      = data_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = gnt_id ? op_e'(req1_op) : op_e'(req0_op);
                    rem_d   = gnt_id ? req1_cnt : req0_cnt;
                    data_d  = gnt_id ? req1_data : req0_data;
                    id_d    = gnt_id;
                    rr_d    = !gnt_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_shift) begin
                    rem_d = rem_q - {1'b0, step_amt};
                end
                if (last_step) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            rem_q       <= '0;
            op_q        <= OP_READ;
            data_q      <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            data_q      <= data_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // The register only moves in EXEC, so it doubles as the held response data.
    shift_core #(.DW(DW)) u_core (
        .clk   (clk),
        .rst   (rst),
        .ld    (in_exec && (op_q == OP_LOAD)),
        .sr    (in_exec && (op_q == OP_SHR)),
        .sl    (in_exec && (op_q == OP_SHL)),
        .s_cnt (step_amt),
        .d_in  (data_q),
        .q     (rsp_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: doc/shift_arb_ctrl.md
SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 4, giving the width of the shared shift register and data paths.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports reqN_valid  input  1  command valid from requester N, for N = 0 and 1.
REQ-005 The block SHALL have ports reqN_ready  output  1  command accepted from requester N.
REQ-006 The block SHALL have ports reqN_op  input  2  opcode: 00 READ, 01 LOAD, 10 SHR, 11 SHL.
REQ-007 The block SHALL have ports reqN_cnt  input  3  shift distance, 0..7.
REQ-008 The block SHALL have ports reqN_data  input  DW  LOAD data.
REQ-009 The block SHALL have port rsp_valid  output  1  response valid.
REQ-010 The block SHALL have port rsp_ready  input  1  response consumer ready.
REQ-011 The block SHALL have port rsp_id  output  1  index of the requester being answered.
REQ-012 The block SHALL have port rsp_data  output  DW  shift register contents after the command.

Function
REQ-013 The block SHALL own one DW-bit shift register, shared by both requesters and accessed only through this block.
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-015 In IDLE, reqN_ready SHALL be high only for the granted requester; both SHALL be low in EXEC and RESP.
REQ-016 A command SHALL be accepted when reqN_valid and reqN_ready are both high at a clock edge; the block SHALL then latch op, cnt, data and id, and enter EXEC.
REQ-017 Arbitration SHALL be round-robin with priority pointer rr.
  - rr reset value is 0, so req0 is preferred.
  - After a grant to requester i, rr SHALL point to the other requester.
  - A lone valid requester SHALL be granted regardless of rr.
REQ-018 In EXEC, each cycle SHALL perform one step on the register:
  - LOAD: register <= data, in 1 step.
  - READ: no change, in 1 step.
  - SHR/SHL: logical shift by min(remaining,3), then remaining -= that amount.
REQ-019 For SHR/SHL, the step count SHALL be max(1, ceil(cnt/3)); cnt=0 SHALL take 1 step with no change.
REQ-020 Shifted-in bits SHALL be 0; for DW=4, any cnt >= 4 SHALL leave the register at 0.
REQ-021 After the last EXEC step the block SHALL enter RESP, with rsp_valid=1, rsp_id = latched id and rsp_data = the updated register.
REQ-022 rsp_valid, rsp_id and rsp_data SHALL hold stable until rsp_ready=1 at a clock edge; the block SHALL then return to IDLE.
REQ-023 Latency from the accept edge to rsp_valid SHALL be exactly the number of steps in cycles (LOAD: 1 cycle; SHL with cnt=7: 3 cycles).
REQ-024 Requests arriving during EXEC or RESP SHALL wait, unaccepted; a requester SHALL be able to hold valid indefinitely without loss.
REQ-025 The block SHALL accept no new command in the same cycle as a response handshake; the minimum command spacing SHALL be steps + 2 cycles.

Reset
REQ-026 While rst=1, the FSM SHALL go to IDLE and the register, rr, remaining, rsp_valid, rsp_id, rsp_data and both reqN_ready SHALL all go to 0.
REQ-027 Reset asserted during EXEC or RESP SHALL abandon the in-flight command without producing a response.
REQ-028 The first accept SHALL be possible on the first edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the DW default, the opcode enum (READ/LOAD/SHR/SHL) and the FSM state enum.
REQ-030 The register SHALL be a sub-module shift_core with inputs ld, sr, sl, s_cnt[1:0], d_in[DW-1:0] and synchronous reset, and output q.
REQ-031 shift_arb_ctrl SHALL contain the FSM, the arbiter, the step counter and the response registers only.

Verification
REQ-032 After reset, req0 LOAD data=4'b1011 -> accept next edge; rsp_valid 1 cycle later with rsp_id=0 and rsp_data=1011.
REQ-033 Register=1011, req1 SHR cnt=2 -> 1 EXEC cycle; rsp_data=0010, rsp_id=1.
REQ-034 Register=0001, req0 SHL cnt=7 -> 3 EXEC steps (3,3,1); rsp_data=0000, with rsp_valid exactly 3 cycles after accept.
REQ-035 Both requesters valid continuously with READ -> grants alternate 0,1,0,1, and no requester is granted twice in a row.
REQ-036 rsp_ready held low for 5 cycles -> rsp_* stable and both reqN_ready low throughout; IDLE follows the handshake.
REQ-037 rst pulsed in the middle of a SHL cnt=6 -> no response issued, register=0, and the next accept behaves as after power-up (req0 preferred).
